// File: rtl/sensor_hub_pkg.sv
// Shared register-map definitions for the MMIO beam-break sensor hub.
// The level register sits directly after the last per-channel counter.
package sensor_hub_pkg;

    typedef logic [3:0] regOffset_t;

    localparam regOffset_t OFF_PENDING = 4'd0;
    localparam regOffset_t OFF_COUNT0  = 4'd1;

    function automatic regOffset_t levelOffset(input int numCh);
        return regOffset_t'(numCh + 1);
    endfunction

endpackage

// File: rtl/sensor_debounce.sv
// One sensor channel: two-flop synchroniser, stability counter and debounced level.
// o_rise fires combinationally in the cycle whose closing edge takes the level 0->1.
module sensor_debounce #(
    parameter int DEBOUNCE_CYCLES = 30000,
    parameter bit ACTIVE_LOW      = 1'b1
) (
    input  logic i_clock,
    input  logic i_reset,
    input  logic i_sensor,
    output logic o_level,
    output logic o_rise
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] LAST_COUNT = CW'(DEBOUNCE_CYCLES - 1);

    logic          r_sync1;
    logic          r_sync2;
    logic          r_level;
    logic [CW-1:0] r_debounceCnt;
    logic          w_sample;
    logic          w_differs;
    logic          w_expire;

    // Reset loads the beam-intact pin value so no phantom edge follows reset
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_sync1 <= ACTIVE_LOW;
            r_sync2 <= ACTIVE_LOW;
        end else begin
            r_sync1 <= i_sensor;
            r_sync2 <= r_sync1;
        end
    end

    assign w_sample  = r_sync2 ^ ACTIVE_LOW;
    assign w_differs = (w_sample != r_level);
    assign w_expire  = w_differs && (r_debounceCnt == LAST_COUNT);

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_level       <= 1'b0;
            r_debounceCnt <= '0;
        end else if (!w_differs) begin
            r_debounceCnt <= '0;
        end else if (w_expire) begin
            r_level       <= w_sample;
            r_debounceCnt <= '0;
        end else begin
            r_debounceCnt <= r_debounceCnt + CW'(1);
        end
    end

    assign o_level = r_level;
    assign o_rise  = w_expire && w_sample;

endmodule

// File: rtl/mmio_sensor_hub.sv
// MMIO hub for beam-break coin sensors: debounced levels, W1C pending events
// and saturating per-channel event counters in a 16-word register window.
module mmio_sensor_hub
    import sensor_hub_pkg::*;
#(
    parameter int          NUM_CH          = 4,
    parameter int          DEBOUNCE_CYCLES = 30000,
    parameter int          CNT_W           = 16,
    parameter logic [11:0] BASE_ADDR       = 12'h000,
    parameter bit          ACTIVE_LOW      = 1'b1
) (
    input  logic              i_clock,
    input  logic              i_reset,
    input  logic [NUM_CH-1:0] i_sensor_in,
    input  logic [11:0]       i_addr,
    input  logic              i_wren,
    input  logic [31:0]       i_data_in,
    output logic [31:0]       o_rd_data,
    output logic              o_rd_hit,
    output logic              o_irq_pending,
    output logic [NUM_CH-1:0] o_level
);

    localparam regOffset_t LEVEL_OFF = levelOffset(NUM_CH);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [NUM_CH-1:0] w_level;
    logic [NUM_CH-1:0] w_rise;
    logic [NUM_CH-1:0] r_pending;
    logic [NUM_CH-1:0] w_clearMask;
    logic [CNT_W-1:0]  r_count     [NUM_CH];
    logic [CNT_W-1:0]  w_countBase [NUM_CH];
    logic              w_hit;
    logic              w_write;
    regOffset_t        w_offset;
    logic [31:0]       w_rdData;
    logic              w_unused;

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_channel
        sensor_debounce #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .ACTIVE_LOW      (ACTIVE_LOW)
        ) u_debounce (
            .i_clock  (i_clock),
            .i_reset  (i_reset),
            .i_sensor (i_sensor_in[gi]),
            .o_level  (w_level[gi]),
            .o_rise   (w_rise[gi])
        );
    end

    assign w_offset = i_addr[3:0];
    assign w_hit    = (i_addr[11:4] == BASE_ADDR[11:4]);
    assign w_write  = i_wren && w_hit;
    assign w_unused = ^i_data_in;

    assign w_clearMask = (w_write && (w_offset == OFF_PENDING)) ? i_data_in[NUM_CH-1:0] : '0;

    // A new event always beats a simultaneous W1C on the same channel
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_pending <= '0;
        end else begin
            r_pending <= w_rise | (r_pending & ~w_clearMask);
        end
    end

    // A software load and an event on the same edge combine as load-then-increment
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            w_countBase[i] = r_count[i];
            if (w_write && (w_offset == regOffset_t'(int'(OFF_COUNT0) + i))) begin
                w_countBase[i] = i_data_in[CNT_W-1:0];
            end
        end
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            for (int i = 0; i < NUM_CH; i++) begin
                r_count[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (w_rise[i] && (w_countBase[i] != CNT_MAX)) begin
                    r_count[i] <= w_countBase[i] + CNT_W'(1);
                end else begin
                    r_count[i] <= w_countBase[i];
                end
            end
        end
    end

    always_comb begin
        w_rdData = '0;
        if (w_hit) begin
            if (w_offset == OFF_PENDING) begin
                w_rdData = 32'(r_pending);
            end else if (w_offset == LEVEL_OFF) begin
                w_rdData = 32'(w_level);
            end
            for (int i = 0; i < NUM_CH; i++) begin
                if (w_offset == regOffset_t'(int'(OFF_COUNT0) + i)) begin
                    w_rdData = 32'(r_count[i]);
                end
            end
        end
    end

    assign o_rd_data     = w_rdData;
    assign o_rd_hit      = w_hit;
    assign o_irq_pending = |r_pending;
    assign o_level       = w_level;

endmodule
